// File: rtl/a2d_spi_intf_pkg.sv
// Shared types and constants for the A2D SPI interface: top FSM state
// encoding, SCLK divider compare points and SPI frame length.
package a2d_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FRAME1 = 2'd1,
    GAP    = 2'd2,
    FRAME2 = 2'd3
  } a2d_state_t;

  // Divider value on the clock before SCLK rises (MISO sample point).
  localparam logic [4:0] RISE_CNT = 5'b01111;
  // Divider value on the clock before SCLK falls (shift point).
  localparam logic [4:0] FALL_CNT = 5'b11111;
  // Divider preload on wrt: 8 counts to the first fall gives the front porch.
  localparam logic [4:0] LOAD_CNT = 5'b10111;

  localparam int FRAME_BITS = 16;

  // ADC128S command word: two don't-care bits, channel address, padding.
  function automatic logic [15:0] build_cmd(input logic [2:0] ch, input logic [10:0] pad);
    return {2'b00, ch, pad};
  endfunction

endpackage

// File: rtl/a2d_spi_intf_if.sv
// Bundle of the conversion request/result signals and the SPI pins.
// The master modport is the converter side, the slave modport is the
// requester plus ADC side.
interface a2d_spi_intf_if;

  logic        start_conv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  start_conv,
    input  chnnl,
    input  MISO,
    output cnv_cmplt,
    output A2D_res,
    output SS_n,
    output SCLK,
    output MOSI
  );

  modport slave (
    output start_conv,
    output chnnl,
    output MISO,
    input  cnv_cmplt,
    input  A2D_res,
    input  SS_n,
    input  SCLK,
    input  MOSI
  );

endinterface

// File: rtl/a2d_spi_intf_spi_mstr16.sv
// 16-bit SPI master, mode 3 (SCLK idles high, MISO sampled on rising edge,
// data shifted on falling edge). A wrt pulse starts one frame; done pulses
// combinationally on the clock whose edge performs the 16th shift, with
// rd_data already presenting the post-shift word.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  // Compare points are defined for the default 5-bit divider.
  localparam logic [SCLK_DIV_W-1:0] L_RISE = SCLK_DIV_W'(RISE_CNT);
  localparam logic [SCLK_DIV_W-1:0] L_FALL = SCLK_DIV_W'(FALL_CNT);
  localparam logic [SCLK_DIV_W-1:0] L_LOAD = SCLK_DIV_W'(LOAD_CNT);
  localparam logic [SCLK_DIV_W-1:0] L_ONE  = SCLK_DIV_W'(1);
  localparam logic [4:0]            L_LAST = 5'(FRAME_BITS - 1);

  logic                  r_ss_n;
  logic [SCLK_DIV_W-1:0] r_div;
  logic [15:0]           r_shift;
  logic [4:0]            r_bit_cnt;
  logic                  r_miso;
  logic                  r_porch_done;

  logic w_rise;
  logic w_fall;
  logic w_shift;

  assign w_rise  = !r_ss_n && (r_div == L_RISE);
  assign w_fall  = !r_ss_n && (r_div == L_FALL);
  // The first fall of a frame is the front porch and moves no data.
  assign w_shift = w_fall && r_porch_done;

  // Frame engine: divider, front-porch flag, shift register, bit count, SS_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n       <= 1'b1;
      r_div        <= '0;
      r_shift      <= 16'h0000;
      r_bit_cnt    <= 5'd0;
      r_porch_done <= 1'b0;
    end else if (wrt) begin
      r_ss_n       <= 1'b0;
      r_div        <= L_LOAD;
      r_shift      <= cmd;
      r_bit_cnt    <= 5'd0;
      r_porch_done <= 1'b0;
    end else if (!r_ss_n) begin
      r_div <= r_div + L_ONE;
      if (w_fall && !r_porch_done) begin
        r_porch_done <= 1'b1;
      end else if (w_shift) begin
        r_shift   <= {r_shift[14:0], r_miso};
        r_bit_cnt <= r_bit_cnt + 5'd1;
        if (r_bit_cnt == L_LAST) begin
          r_ss_n <= 1'b1;
        end
      end
    end
  end

  // MISO holding flop, loaded at the SCLK rising point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso <= 1'b0;
    end else if (w_rise) begin
      r_miso <= MISO;
    end
  end

  assign done    = w_shift && (r_bit_cnt == L_LAST);
  assign rd_data = {r_shift[14:0], r_miso};
  assign SS_n    = r_ss_n;
  assign SCLK    = r_ss_n | r_div[SCLK_DIV_W-1];
  assign MOSI    = r_shift[15];

endmodule

// File: rtl/a2d_spi_intf.sv
// A2D SPI interface top: each accepted start_conv runs two 16-bit SPI
// frames carrying the same channel command, separated by a one-clock SS_n
// high gap; the second frame's low 12 bits become A2D_res and set the
// sticky cnv_cmplt flag.
module a2d_spi_intf
  import a2d_pkg::*;
#(
  parameter int          SCLK_DIV_W = 5,
  parameter logic [10:0] CMD_PAD    = 11'h000
) (
  input  logic           clk,
  input  logic           rst_n,
  a2d_spi_intf_if.master bus
);

  a2d_state_t  r_state;
  a2d_state_t  w_next_state;
  logic [2:0]  r_chnnl;
  logic [11:0] r_a2d_res;
  logic        r_cnv_cmplt;

  logic        w_wrt;
  logic [15:0] w_cmd;
  logic        w_accept;
  logic        w_finish;
  logic        w_done;
  logic [15:0] w_rd_data;
  logic        w_unused_hi;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start_conv is only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start_conv) begin
          w_next_state = FRAME1;
        end else begin
          w_next_state = IDLE;
        end
      end
      FRAME1: begin
        if (w_done) begin
          w_next_state = GAP;
        end else begin
          w_next_state = FRAME1;
        end
      end
      GAP: begin
        w_next_state = FRAME2;
      end
      FRAME2: begin
        if (w_done) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = FRAME2;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM outputs: frame launch, command select, accept and finish strobes.
  // In IDLE the command is built from the live chnnl because the latch
  // only captures it on this same edge.
  always_comb begin
    w_wrt    = 1'b0;
    w_cmd    = build_cmd(r_chnnl, CMD_PAD);
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_conv) begin
          w_wrt    = 1'b1;
          w_cmd    = build_cmd(bus.chnnl, CMD_PAD);
          w_accept = 1'b1;
        end else begin
          w_wrt    = 1'b0;
          w_accept = 1'b0;
        end
      end
      GAP: begin
        w_wrt = 1'b1;
      end
      FRAME2: begin
        w_finish = w_done;
      end
      default: begin
        w_wrt    = 1'b0;
        w_finish = 1'b0;
      end
    endcase
  end

  // Channel latch so mid-conversion chnnl changes cannot alter frame 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chnnl <= 3'd0;
    end else if (w_accept) begin
      r_chnnl <= bus.chnnl;
    end
  end

  // Result and sticky completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a2d_res   <= 12'h000;
      r_cnv_cmplt <= 1'b0;
    end else if (w_finish) begin
      r_a2d_res   <= w_rd_data[11:0];
      r_cnv_cmplt <= 1'b1;
    end else if (w_accept) begin
      r_cnv_cmplt <= 1'b0;
    end
  end

  // The ADC's upper four bits carry no data.
  assign w_unused_hi = ^w_rd_data[15:12];

  spi_mstr16 #(
    .SCLK_DIV_W(SCLK_DIV_W)
  ) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (w_wrt),
    .cmd     (w_cmd),
    .MISO    (bus.MISO),
    .done    (w_done),
    .rd_data (w_rd_data),
    .SS_n    (bus.SS_n),
    .SCLK    (bus.SCLK),
    .MOSI    (bus.MOSI)
  );

  assign bus.cnv_cmplt = r_cnv_cmplt;
  assign bus.A2D_res   = r_a2d_res;

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Bench for a2d_spi_intf: an ADC128S-style slave model answers each
// frame with the value of the channel addressed in the previous frame,
// while a monitor measures SCLK/SS_n timing and collects MOSI words.
module tb_a2d_spi_intf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  a2d_spi_intf_if bus();

  a2d_spi_intf #(.SCLK_DIV_W(5), .CMD_PAD(11'h000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] chan_val [8];

  // slave model / monitor state
  logic        adc_odd = 1'b0;
  logic [2:0]  adc_ch = 3'd0;
  logic [15:0] adc_word = 16'h0000;
  logic [15:0] adc_junk = 16'h5A5A;
  int          adc_idx = 0;
  int          fall_cnt = 0;
  logic [15:0] mosi_sh = 16'h0000;
  int          nbits = 0;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  int          t_in_frame = 0;
  int          rises = 0;
  int          first_fall = -1;
  int          last_rise_t = -1;
  logic        period_bad = 1'b0;
  int          frames_done = 0;
  int          bad_frames = 0;
  int          idle_toggles = 0;
  int          ss_high_cnt = 0;
  int          last_gap = 0;
  int          last_rises = 0;
  int          last_first_fall = 0;
  logic        last_period_bad = 1'b0;
  logic [15:0] mosi_q [$];

  function automatic logic [15:0] adc_sel(input logic odd, input logic [2:0] ch, input logic [15:0] junk);
    return odd ? chan_val[ch] : junk;
  endfunction

  // slave model and timing monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ss   <= 1'b1;
      prev_sclk <= 1'b1;
      adc_odd   <= 1'b0;
      adc_ch    <= 3'd0;
      bus.MISO  <= 1'b0;
      nbits     <= 0;
      rises     <= 0;
      ss_high_cnt <= 0;
    end else begin
      prev_ss   <= bus.SS_n;
      prev_sclk <= bus.SCLK;
      if (bus.SS_n && !bus.SCLK) idle_toggles <= idle_toggles + 1;
      if (prev_ss && !bus.SS_n) begin
        last_gap    <= ss_high_cnt;
        ss_high_cnt <= 0;
        adc_word    <= adc_sel(adc_odd, adc_ch, adc_junk);
        bus.MISO    <= adc_sel(adc_odd, adc_ch, adc_junk) >> 15;
        adc_idx     <= 15;
        fall_cnt    <= 0;
        nbits       <= 0;
        t_in_frame  <= 0;
        rises       <= 0;
        first_fall  <= -1;
        last_rise_t <= -1;
        period_bad  <= 1'b0;
      end else if (!bus.SS_n) begin
        t_in_frame <= t_in_frame + 1;
        if (prev_sclk && !bus.SCLK) begin
          if (first_fall < 0) first_fall <= t_in_frame + 1;
          fall_cnt <= fall_cnt + 1;
          if (fall_cnt >= 1 && adc_idx > 0) begin
            adc_idx  <= adc_idx - 1;
            bus.MISO <= adc_word[4'(adc_idx - 1)];
          end
        end
        if (!prev_sclk && bus.SCLK) begin
          rises   <= rises + 1;
          mosi_sh <= {mosi_sh[14:0], bus.MOSI};
          nbits   <= nbits + 1;
          if (last_rise_t >= 0 && (t_in_frame + 1 - last_rise_t) != 32) period_bad <= 1'b1;
          last_rise_t <= t_in_frame + 1;
        end
      end else begin
        ss_high_cnt <= ss_high_cnt + 1;
        if (!prev_ss) begin
          frames_done     <= frames_done + 1;
          last_rises      <= rises;
          last_first_fall <= first_fall;
          last_period_bad <= period_bad;
          if (rises != 16 || first_fall != 9 || period_bad) bad_frames <= bad_frames + 1;
          if (nbits == 16) mosi_q.push_back(mosi_sh);
          adc_ch   <= mosi_sh[13:11];
          adc_odd  <= !adc_odd;
          adc_junk <= 16'($urandom);
        end
      end
    end
  end

  // Runs one conversion from a point #1 after a posedge; returns latency
  // in clocks and the cnv_cmplt seen one clock after start_conv. Optional
  // stray start_conv pulses with chnnl=7 at clocks 100 and 600.
  task automatic do_conv(input logic [2:0] ch, input bit noisy, output int lat, output logic cmplt_after);
    bus.start_conv = 1'b1;
    bus.chnnl = ch;
    @(posedge clk); #1;
    bus.start_conv = 1'b0;
    cmplt_after = bus.cnv_cmplt;
    lat = -1;
    for (int n = 1; n <= 2000; n++) begin
      if (noisy) begin
        bus.start_conv = (n == 100 || n == 600);
        bus.chnnl = (n >= 100) ? 3'd7 : ch;
      end
      @(posedge clk); #1;
      if (bus.cnv_cmplt) begin
        lat = n;
        break;
      end
    end
    bus.start_conv = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] exp_cmd(input logic [2:0] ch);
    return 16'(ch) * 16'd2048;
  endfunction

  function automatic logic [11:0] exp_res(input logic [2:0] ch);
    return 12'(chan_val[ch] % 16'd4096);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_conv = 1'b0;
    bus.chnnl = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.SS_n !== 1'b1 || bus.SCLK !== 1'b1 || bus.MOSI !== 1'b0 ||
        bus.cnv_cmplt !== 1'b0 || bus.A2D_res !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_state: got SS_n=%b SCLK=%b MOSI=%b cmplt=%b res=%h, expected 1 1 0 0 000",
               bus.SS_n, bus.SCLK, bus.MOSI, bus.cnv_cmplt, bus.A2D_res);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat; logic c0; int f0;
    chan_val[4] = 16'h0ABC;
    mosi_q.delete();
    f0 = frames_done;
    do_conv(3'd4, 1'b0, lat, c0);
    tests_run++;
    if (lat !== 1043) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 1043", lat); end
    tests_run++;
    if (bus.A2D_res !== 12'hABC) begin tests_failed++; $display("FAIL basic_result: got %h expected abc", bus.A2D_res); end
    tests_run++;
    if (bus.cnv_cmplt !== 1'b1) begin tests_failed++; $display("FAIL basic_sticky: got %b expected 1", bus.cnv_cmplt); end
    tests_run++;
    if (mosi_q.size() != 2 || mosi_q[0] !== 16'h2000 || mosi_q[1] !== 16'h2000) begin
      tests_failed++;
      $display("FAIL basic_mosi: got %0d words first %h, expected 2 words 2000", mosi_q.size(),
               (mosi_q.size() > 0) ? mosi_q[0] : 16'hxxxx);
    end
    tests_run++;
    if (last_gap != 1) begin tests_failed++; $display("FAIL basic_gap: got %0d expected 1", last_gap); end
    tests_run++;
    if (frames_done - f0 != 2) begin tests_failed++; $display("FAIL basic_frames: got %0d expected 2", frames_done - f0); end
  endtask

  task automatic test_sclk_timing();
    int lat; logic c0; logic [2:0] ch;
    ch = 3'($urandom_range(0, 7));
    chan_val[ch] = 16'($urandom);
    do_conv(ch, 1'b0, lat, c0);
    tests_run++;
    if (last_rises != 16) begin tests_failed++; $display("FAIL sclk_rises: got %0d expected 16", last_rises); end
    tests_run++;
    if (last_first_fall != 9) begin tests_failed++; $display("FAIL sclk_first_fall: got %0d expected 9", last_first_fall); end
    tests_run++;
    if (last_period_bad !== 1'b0) begin tests_failed++; $display("FAIL sclk_period: got bad=%b expected 0", last_period_bad); end
    tests_run++;
    if (bad_frames != 0) begin tests_failed++; $display("FAIL sclk_all_frames: got %0d bad expected 0", bad_frames); end
    tests_run++;
    if (idle_toggles != 0) begin tests_failed++; $display("FAIL sclk_idle: got %0d low samples expected 0", idle_toggles); end
  endtask

  task automatic test_ignore_start();
    int lat; logic c0; int f0;
    chan_val[2] = 16'($urandom);
    chan_val[7] = ~chan_val[2];
    mosi_q.delete();
    f0 = frames_done;
    do_conv(3'd2, 1'b1, lat, c0);
    repeat (60) @(posedge clk);
    #1;
    tests_run++;
    if (lat !== 1043) begin tests_failed++; $display("FAIL ignore_latency: got %0d expected 1043", lat); end
    tests_run++;
    if (bus.A2D_res !== exp_res(3'd2)) begin
      tests_failed++; $display("FAIL ignore_result: got %h expected %h", bus.A2D_res, exp_res(3'd2));
    end
    tests_run++;
    if (mosi_q.size() != 2 || mosi_q[0] !== 16'h1000 || mosi_q[1] !== 16'h1000) begin
      tests_failed++;
      $display("FAIL ignore_mosi: got %0d words first %h, expected 2 words 1000", mosi_q.size(),
               (mosi_q.size() > 0) ? mosi_q[0] : 16'hxxxx);
    end
    tests_run++;
    if (frames_done - f0 != 2 || bus.SS_n !== 1'b1) begin
      tests_failed++; $display("FAIL ignore_no_queue: got %0d frames SS_n=%b expected 2 and 1", frames_done - f0, bus.SS_n);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic c0; logic [2:0] ch;
    bus.start_conv = 1'b1;
    bus.chnnl = 3'd3;
    @(posedge clk); #1;
    bus.start_conv = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    tests_run++;
    if (bus.SS_n !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_frame: got SS_n=%b expected 0", bus.SS_n); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.SS_n !== 1'b1 || bus.SCLK !== 1'b1 || bus.MOSI !== 1'b0 ||
        bus.cnv_cmplt !== 1'b0 || bus.A2D_res !== 12'h000) begin
      tests_failed++;
      $display("FAIL midrst_state: got SS_n=%b SCLK=%b MOSI=%b cmplt=%b res=%h, expected 1 1 0 0 000",
               bus.SS_n, bus.SCLK, bus.MOSI, bus.cnv_cmplt, bus.A2D_res);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ch = 3'($urandom_range(0, 7));
    chan_val[ch] = 16'($urandom) | 16'h0001;
    do_conv(ch, 1'b0, lat, c0);
    tests_run++;
    if (lat !== 1043) begin tests_failed++; $display("FAIL midrst_latency: got %0d expected 1043", lat); end
    tests_run++;
    if (bus.A2D_res !== exp_res(ch)) begin
      tests_failed++; $display("FAIL midrst_result: got %h expected %h", bus.A2D_res, exp_res(ch));
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  chs  [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    logic [11:0] vals [6] = '{12'h001, 12'h123, 12'h456, 12'h789, 12'hABC, 12'hFFF};
    int lat; logic c0;
    for (int i = 0; i < 6; i++) begin
      chan_val[chs[i]] = {4'($urandom), vals[i]};
      do_conv(chs[i], 1'b0, lat, c0);
      tests_run++;
      if (c0 !== 1'b0) begin tests_failed++; $display("FAIL b2b_clear[%0d]: got %b expected 0", i, c0); end
      tests_run++;
      if (lat !== 1043) begin tests_failed++; $display("FAIL b2b_latency[%0d]: got %0d expected 1043", i, lat); end
      tests_run++;
      if (bus.A2D_res !== vals[i]) begin
        tests_failed++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, bus.A2D_res, vals[i]);
      end
    end
  endtask

  task automatic test_all_ones();
    int lat; logic c0;
    chan_val[5] = 16'hFFFF;
    chan_val[6] = 16'($urandom) & 16'h0FFF;
    do_conv(3'd5, 1'b0, lat, c0);
    tests_run++;
    if (bus.A2D_res !== 12'hFFF || lat !== 1043) begin
      tests_failed++; $display("FAIL ones_result: got %h lat %0d expected fff lat 1043", bus.A2D_res, lat);
    end
    do_conv(3'd6, 1'b0, lat, c0);
    tests_run++;
    if (bus.A2D_res !== exp_res(3'd6) || lat !== 1043) begin
      tests_failed++; $display("FAIL ones_followup: got %h lat %0d expected %h lat 1043", bus.A2D_res, lat, exp_res(3'd6));
    end
  endtask

  task automatic test_random();
    int lat; logic c0; logic [2:0] ch;
    for (int i = 0; i < 4; i++) begin
      ch = 3'($urandom_range(0, 7));
      chan_val[ch] = 16'($urandom);
      mosi_q.delete();
      do_conv(ch, 1'b0, lat, c0);
      tests_run++;
      if (bus.A2D_res !== exp_res(ch) || lat !== 1043) begin
        tests_failed++; $display("FAIL rand_result[%0d]: got %h lat %0d expected %h lat 1043", i, bus.A2D_res, lat, exp_res(ch));
      end
      tests_run++;
      if (mosi_q.size() != 2 || mosi_q[0] !== exp_cmd(ch)) begin
        tests_failed++; $display("FAIL rand_cmd[%0d]: got %0d words expected 2 of %h", i, mosi_q.size(), exp_cmd(ch));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) chan_val[i] = 16'h0000;
    bus.start_conv = 1'b0;
    bus.chnnl = 3'd0;
    test_reset();
    test_basic();
    test_sclk_timing();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_all_ones();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/a2d_spi_intf.md
Name: a2d_spi_intf

Overview:
- Upstream stage of the line-follower motion controller: turns its start_conv/chnnl requests into ADC128S-style SPI reads and returns a 12-bit result with a completion flag.
- Each conversion is two back-to-back 16-bit SPI frames:
  - first frame sends the channel number;
  - second frame reads the result for that channel.
- Contains one SPI master sub-module; no other clock domains.

Parameters:
- SCLK_DIV_W, 5: width of the SCLK divider counter; SCLK period = 2^SCLK_DIV_W clk cycles (32).
- CMD_PAD, 11'h000: low 11 bits of the command word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start_conv  in  1  one-clock request to begin a conversion
- chnnl  in  3  ADC channel; sampled on the start_conv clock
- cnv_cmplt  out  1  sticky conversion-done flag
- A2D_res  out  12  conversion result
- SS_n  out  1  SPI slave select, active low
- SCLK  out  1  SPI clock, idles high
- MOSI  out  1  SPI data to ADC
- MISO  in  1  SPI data from ADC

Behaviour:
- Reset values (asynchronous, at any point including mid-frame):
  - SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, A2D_res=12'h000;
  - FSM to IDLE; divider, bit counter and shift register cleared.
- Top FSM states: IDLE, FRAME1, GAP, FRAME2.
  - IDLE & start_conv: latch chnnl, clear cnv_cmplt, pulse wrt with cmd={2'b00,chnnl,CMD_PAD}, go to FRAME1.
  - FRAME1 & done: go to GAP.
  - GAP: stays exactly 1 clock with SS_n high, then pulses wrt with the same cmd and goes to FRAME2.
  - FRAME2 & done: A2D_res<=rd_data[11:0] and cnv_cmplt<=1 on the same clock edge, then return to IDLE.
- start_conv outside IDLE: ignored; no queueing; a chnnl change mid-conversion has no effect.
- cnv_cmplt: stays 1 until the next accepted start_conv, which clears it on the following edge. A2D_res holds its last value until overwritten.
- SPI master frame timing, measured from the wrt edge:
  - wrt: SS_n<=0, divider<=5'b10111, shift reg<=cmd, bit count<=0; MOSI=shift[15] throughout.
  - SCLK=divider[SCLK_DIV_W-1], forced to 1 whenever SS_n=1.
  - Rising edge (divider==5'b01111): sample MISO into a holding flop.
  - Falling edge (divider==5'b11111):
    - first one (front porch): no shift;
    - each later one: shift left, inserting the held MISO bit, and increment bit count.
  - The 16th shift completes the frame on that same clock: SS_n<=1, SCLK forced high, done pulses 1 clock.
  - done is exactly 521 clocks after the wrt edge (9 front porch + 16×32).
- Whole conversion: start_conv edge to cnv_cmplt=1 takes 521+1+521 = 1043 clocks.
- rd_data = shift register after the 16th shift; bit 15 is the first MISO bit received.
- Width rules: A2D_res is the unsigned low 12 bits; the upper 4 received bits are discarded.

Decomposition:
- Shared package a2d_pkg:
  - FSM state typedef (IDLE, FRAME1, GAP, FRAME2);
  - divider constants RISE_CNT=5'b01111, FALL_CNT=5'b11111, LOAD_CNT=5'b10111;
  - FRAME_BITS=16.
- Sub-module spi_mstr16 (clk, rst_n, wrt, cmd[15:0], MISO → done, rd_data[15:0], SS_n, SCLK, MOSI). It owns the divider, bit counter, shift register and MISO holding flop.
- Top level holds only the FSM, latched command, result and flag registers.

Test Plan:
- Reset mid-FRAME1 (rst_n low ~200 clocks after start_conv) → SS_n=1, SCLK=1, cnv_cmplt=0, A2D_res=0 immediately. After release, a new start_conv completes normally in 1043 clocks.
- start_conv with chnnl=3'd4; ADC model returns 16'h0ABC in frame 2 →
  - frame-1 MOSI bits = 16'h2000;
  - A2D_res=12'hABC and cnv_cmplt=1 exactly 1043 clocks after start_conv;
  - SS_n high for exactly 1 clock between frames.
- Check SCLK per frame: exactly 16 rising edges, period 32 clks, first falling edge 9 clks after SS_n falls, SCLK never toggles while SS_n=1.
- Extra start_conv pulses with chnnl=7 at clock 100 and clock 600 of a chnnl=2 conversion → both ignored; frame-1 command 16'h1000; the single result is unaffected.
- Back-to-back conversions on channels 1,0,4,2,3,7 with model values 12'h001…12'hFFF → each cnv_cmplt clears one clock after its start_conv, and each A2D_res matches its channel's value in order.
- ADC model driving all-ones in frame 2 → A2D_res=12'hFFF; the upper 4 bits are dropped, with no overflow into other state.
